uart_buffered: RTL and testbench

Parametrised, FIFO-buffered 8-bit UART for the clk_48 domain: the next-generation replacement for the fixed-rate, unbuffered uart wrapper. It adds a runtime baud divisor, optional parity, TX and RX FIFOs of configurable depth, and per-byte error flags plus an overflow indication. It is self-contained (own baud generator, transmitter, receiver) and sits between the pins and the host-side stream logic.

---
 rtl/uart_buffered_if.sv | 31 +++
 rtl/uart_buffered.sv | 262 ++++++++++++++++++++++++++
 tb/tb_uart_buffered.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_buffered_if.sv
// Host-side stream bundle of uart_buffered: TX byte stream in, RX byte stream
// with per-byte error flags out, plus FIFO occupancy and overflow indication.
interface uart_buffered_if #(
  parameter int FIFO_AW = 4
);
  // Valid/ready: a byte moves on every rising clk edge where valid && ready;
  // tx_ready and rx_valid never depend combinationally on tx_valid/rx_ready.
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [FIFO_AW:0] tx_level;
  logic [7:0]       rx_data;
  logic             rx_frame_error;
  logic             rx_parity_error;
  logic             rx_valid;
  logic             rx_ready;
  logic [FIFO_AW:0] rx_level;
  logic             rx_overflow;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, tx_level, rx_data, rx_frame_error, rx_parity_error,
           rx_valid, rx_level, rx_overflow
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, tx_level, rx_data, rx_frame_error, rx_parity_error,
           rx_valid, rx_level, rx_overflow
  );
endinterface

// File: rtl/uart_buffered.sv
// FIFO-buffered 8N1 / 8P1 UART with runtime x16 baud divisor, per-byte error
// flags and RX overflow pulse.
module uart_buffered #(
  parameter int DIV_W   = 16,
  parameter int FIFO_AW = 4,
  parameter int PARITY  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             rxd,
  output logic             txd,
  uart_buffered_if.slave   bus,
  output logic [2:0]       tx_state_dbg,
  output logic [2:0]       rx_state_dbg
);
  localparam int LW    = FIFO_AW + 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_e;

  function automatic logic par_bit(input logic [7:0] d);
    return (PARITY == 1) ? ~^d : ^d;
  endfunction

  // ---------------- baud generator ----------------
  logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
  logic             strobe;
  assign strobe = (baud_cnt_q == '0);
  always_comb baud_cnt_d = strobe ? baud_div : baud_cnt_q - 1'b1;

  // ---------------- TX FIFO ----------------
  logic [7:0]         tx_mem [DEPTH];
  logic [FIFO_AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [FIFO_AW:0]   tx_cnt_q, tx_cnt_d;
  logic               tx_push, tx_pop, tx_empty;
  logic [7:0]         tx_head;

  assign bus.tx_ready = (tx_cnt_q != DEPTH_L);
  assign bus.tx_level = tx_cnt_q;
  assign tx_push  = bus.tx_valid && bus.tx_ready;
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_head  = tx_mem[tx_rd_q];

  always_comb begin
    tx_wr_d  = tx_wr_q + FIFO_AW'(tx_push);
    tx_rd_d  = tx_rd_q + FIFO_AW'(tx_pop);
    tx_cnt_d = tx_cnt_q + LW'(tx_push) - LW'(tx_pop);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_q] <= bus.tx_data;
  end

  // ---------------- transmitter ----------------
  tx_state_e  tx_state_q, tx_state_d;
  logic [3:0] tx_tick_q, tx_tick_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       tx_par_q, tx_par_d;
  logic       tx_bit_end;

  assign tx_bit_end   = strobe && (tx_tick_q == 4'd15);
  assign tx_state_dbg = tx_state_q;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tick_d  = tx_tick_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    if (strobe) tx_tick_d = tx_tick_q + 4'd1;
    case (tx_state_q)
      TX_IDLE: begin
        tx_tick_d = 4'd0;
        if (strobe && !tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_par_d   = par_bit(tx_head);
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_bit_d   = 3'd0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'd7) tx_state_d = (PARITY != 0) ? TX_PARITY : TX_STOP;
        end
      end
      TX_PARITY: if (tx_bit_end) tx_state_d = TX_STOP;
      TX_STOP: begin
        // Reload straight from the FIFO so consecutive frames abut.
        if (tx_bit_end) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_par_d   = par_bit(tx_head);
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    case (tx_state_q)
      TX_START:  txd = 1'b0;
      TX_DATA:   txd = tx_shift_q[0];
      TX_PARITY: txd = tx_par_q;
      default:   txd = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  logic       sync1_q, sync2_q;
  rx_state_e  rx_state_q, rx_state_d;
  logic [3:0] rx_tick_q, rx_tick_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rx_perr_q, rx_perr_d;
  logic       rx_bit_end, push_req;
  logic [9:0] push_word;

  assign rx_bit_end   = strobe && (rx_tick_q == 4'd15);
  assign rx_state_dbg = rx_state_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_perr_d  = rx_perr_q;
    push_req   = 1'b0;
    push_word  = {rx_perr_q, !sync2_q, rx_shift_q};
    if (strobe) rx_tick_d = rx_tick_q + 4'd1;
    case (rx_state_q)
      RX_IDLE: begin
        rx_tick_d = 4'd0;
        if (strobe && !sync2_q) rx_state_d = RX_START;
      end
      RX_START: begin
        // Half a bit in: still low means a real start, re-centre the tick.
        if (strobe && rx_tick_q == 4'd7) begin
          rx_tick_d  = 4'd0;
          rx_bit_d   = 3'd0;
          rx_perr_d  = 1'b0;
          rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_bit_end) begin
          rx_shift_d = {sync2_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
        end
      end
      RX_PARITY: begin
        if (rx_bit_end) begin
          rx_perr_d  = (^{rx_shift_q, sync2_q}) ^ (PARITY == 1);
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_bit_end) begin
          push_req   = 1'b1;
          rx_state_d = sync2_q ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: if (sync2_q) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- RX FIFO (first-word-fall-through) ----------------
  logic [9:0]         rx_mem [DEPTH];
  logic [FIFO_AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [FIFO_AW:0]   rx_cnt_q, rx_cnt_d;
  logic               rx_push, rx_pop, rx_full, ovf_q, ovf_d;
  logic [9:0]         rx_head;

  assign rx_full             = (rx_cnt_q == DEPTH_L);
  assign rx_head             = rx_mem[rx_rd_q];
  assign bus.rx_valid        = (rx_cnt_q != '0);
  assign bus.rx_level        = rx_cnt_q;
  assign bus.rx_data         = rx_head[7:0];
  assign bus.rx_frame_error  = rx_head[8];
  assign bus.rx_parity_error = rx_head[9];
  assign bus.rx_overflow     = ovf_q;
  assign rx_pop              = bus.rx_valid && bus.rx_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign rx_push             = push_req && (!rx_full || rx_pop);

  always_comb begin
    rx_wr_d  = rx_wr_q + FIFO_AW'(rx_push);
    rx_rd_d  = rx_rd_q + FIFO_AW'(rx_pop);
    rx_cnt_d = rx_cnt_q + LW'(rx_push) - LW'(rx_pop);
    ovf_d    = push_req && !rx_push;
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_q] <= push_word;
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt_q <= baud_div;
      tx_wr_q    <= '0;
      tx_rd_q    <= '0;
      tx_cnt_q   <= '0;
      tx_state_q <= TX_IDLE;
      tx_tick_q  <= 4'd0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'd0;
      tx_par_q   <= 1'b0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_tick_q  <= 4'd0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'd0;
      rx_perr_q  <= 1'b0;
      rx_wr_q    <= '0;
      rx_rd_q    <= '0;
      rx_cnt_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      baud_cnt_q <= baud_cnt_d;
      tx_wr_q    <= tx_wr_d;
      tx_rd_q    <= tx_rd_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_state_q <= tx_state_d;
      tx_tick_q  <= tx_tick_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      sync1_q    <= rxd;
      sync2_q    <= sync1_q;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
      rx_wr_q    <= rx_wr_d;
      rx_rd_q    <= rx_rd_d;
      rx_cnt_q   <= rx_cnt_d;
      ovf_q      <= ovf_d;
    end
  end
endmodule

// File: tb/tb_uart_buffered.sv
// Directed bench for uart_buffered (even parity, baud_div = 2, 16-deep FIFOs)
// with a receive-side scoreboard fed by every byte the bench sends.
module tb_uart_buffered;
  localparam int DIV_W   = 16;
  localparam int FIFO_AW = 4;
  localparam int PARITY  = 2;
  localparam int BIT_T   = 48;
  localparam int FRAME_T = 11 * BIT_T;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [DIV_W-1:0] baud_div = 16'd2;
  logic             rxd, txd;
  logic             rxd_drv = 1'b1;
  logic             loop_en = 1'b0;
  logic [2:0]       tx_state_dbg, rx_state_dbg;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ovf_cnt = 0;
  int last_cyc = 0;
  logic gap_chk = 1'b0;
  logic have_last = 1'b0;
  logic [9:0] exp_q[$];

  uart_buffered_if #(.FIFO_AW(FIFO_AW)) bus ();

  assign rxd = loop_en ? txd : rxd_drv;

  uart_buffered #(.DIV_W(DIV_W), .FIFO_AW(FIFO_AW), .PARITY(PARITY)) dut (
    .clk          (clk),
    .rst          (rst),
    .baud_div     (baud_div),
    .rxd          (rxd),
    .txd          (txd),
    .bus          (bus),
    .tx_state_dbg (tx_state_dbg),
    .rx_state_dbg (rx_state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_overflow) ovf_cnt++;
      if (bus.rx_valid && bus.rx_ready) begin
        if (exp_q.size() == 0) begin
          check("rx_unexpected_byte",
                {22'd0, bus.rx_parity_error, bus.rx_frame_error, bus.rx_data}, 32'hFFFF_FFFF);
        end else begin
          check("rx_word", {22'd0, bus.rx_parity_error, bus.rx_frame_error, bus.rx_data},
                {22'd0, exp_q.pop_front()});
          if (gap_chk && have_last) check("rx_frame_spacing", cyc - last_cyc, FRAME_T);
          last_cyc  = cyc;
          have_last = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_tx(input logic [7:0] d);
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
    logic [10:0] bits;
    bits = {stop, (^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rxd_drv = bits[i];
      repeat (BIT_T) @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [10:0] fbits;
    logic [7:0]  b, rx_byte;
    int          n, acc, o0;

    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_tx_ready", bus.tx_ready, 1);
    check("rst_tx_level", bus.tx_level, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_rx_level", bus.rx_level, 0);
    check("rst_rx_overflow", bus.rx_overflow, 0);

    // Loopback 0xA5: bit-accurate txd waveform and clean receive
    loop_en = 1'b1;
    exp_q.push_back({2'b00, 8'hA5});
    write_tx(8'hA5);
    n = 0;
    while (txd !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("tx_start_fall", txd, 0);
    fbits = {1'b1, ^(8'hA5), 8'hA5, 1'b0};
    repeat (BIT_T / 2) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("tx_bit%0d", i), txd, fbits[i]);
      repeat (BIT_T) @(negedge clk);
    end
    wait_drain("loopback_drain", 2 * FRAME_T);
    repeat (BIT_T) @(negedge clk);

    // TX backpressure: fill while holding valid, then watch gapless output
    gap_chk   = 1'b1;
    have_last = 1'b0;
    acc = 0;
    @(negedge clk);
    while (bus.tx_ready && acc < 40) begin
      bus.tx_data  = 8'($urandom_range(0, 255));
      bus.tx_valid = 1'b1;
      exp_q.push_back({2'b00, bus.tx_data});
      acc++;
      @(negedge clk);
    end
    bus.tx_valid = 1'b0;
    check("bp_accepted", acc, 17);
    check("bp_tx_level", bus.tx_level, 16);
    check("bp_tx_ready", bus.tx_ready, 0);
    wait_drain("bp_drain", 19 * FRAME_T);
    gap_chk = 1'b0;
    check("bp_tx_level_empty", bus.tx_level, 0);
    repeat (BIT_T) @(negedge clk);

    // Frame error followed by a long break
    loop_en = 1'b0;
    exp_q.push_back({2'b01, 8'h3C});
    send_frame(8'h3C, 1'b0, 1'b0);
    rxd_drv = 1'b0;
    repeat (40 * BIT_T) @(negedge clk);
    check("ferr_received", exp_q.size(), 0);
    check("ferr_rx_level", bus.rx_level, 0);
    rxd_drv = 1'b1;
    repeat (2 * BIT_T) @(negedge clk);
    exp_q.push_back({2'b00, 8'h5A});
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_drain("after_break_drain", FRAME_T);

    // Parity error
    exp_q.push_back({2'b10, 8'h81});
    send_frame(8'h81, 1'b1, 1'b1);
    wait_drain("perr_drain", FRAME_T);

    // Glitch shorter than half a bit
    @(negedge clk);
    rxd_drv = 1'b0;
    repeat (15) @(negedge clk);
    rxd_drv = 1'b1;
    repeat (FRAME_T) @(negedge clk);
    check("glitch_rx_level", bus.rx_level, 0);

    // Overflow: 17 bytes into a 16-deep FIFO with the consumer stalled
    bus.rx_ready = 1'b0;
    o0 = ovf_cnt;
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < 16) exp_q.push_back({2'b00, b});
      send_frame(b, 1'b1, 1'b0);
    end
    repeat (BIT_T) @(negedge clk);
    check("ovf_rx_level", bus.rx_level, 16);
    check("ovf_pulses", ovf_cnt - o0, 1);
    check("ovf_rx_valid", bus.rx_valid, 1);
    bus.rx_ready = 1'b1;
    wait_drain("ovf_drain", 100);
    @(negedge clk);
    check("ovf_rx_level_empty", bus.rx_level, 0);

    // Reset mid-frame with a byte parked in each FIFO
    bus.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_rst_rx_level", bus.rx_level, 1);
    rx_byte = 8'h6B;
    rxd_drv = 1'b0;
    repeat (BIT_T) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      rxd_drv = rx_byte[i];
      if (i == 1) begin
        bus.tx_data  = 8'hF7;
        bus.tx_valid = 1'b1;
        @(negedge clk);
        bus.tx_data  = 8'h55;
        @(negedge clk);
        bus.tx_valid = 1'b0;
        repeat (BIT_T - 2) @(negedge clk);
      end else begin
        repeat (BIT_T) @(negedge clk);
      end
    end
    rxd_drv = rx_byte[5];
    repeat (BIT_T / 2) @(negedge clk);
    check("pre_rst_txd_bit3", txd, 0);
    check("pre_rst_tx_level", bus.tx_level, 1);
    rst = 1'b1;
    #1;
    check("rst_async_txd", txd, 1);
    check("rst_async_tx_level", bus.tx_level, 0);
    check("rst_async_rx_level", bus.rx_level, 0);
    check("rst_async_rx_valid", bus.rx_valid, 0);
    repeat (3) @(negedge clk);
    rxd_drv      = 1'b1;
    bus.rx_ready = 1'b1;
    rst          = 1'b0;
    repeat (2) @(negedge clk);
    loop_en = 1'b1;
    exp_q.push_back({2'b00, 8'h3A});
    write_tx(8'h3A);
    wait_drain("post_rst_drain", 2 * FRAME_T);
    repeat (BIT_T) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
